vc_switch_driver: RTL and testbench

//  Digital control-side driver for a complementary pair of voltage-controlled hysteretic switches (A, B).

---
 rtl/vc_switch_driver.sv | 121 ++++++++++++
 tb/tb_vc_switch_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_switch_driver.sv
// Break-before-make driver for a complementary switch pair (A, B).
// Produces slew-limited DAC codes with a programmable dead time between transitions.
module vc_switch_driver #(
    parameter int CODE_W   = 8,
    parameter int CODE_ON  = 200,
    parameter int CODE_OFF = 20,
    parameter int STEP     = 10,
    parameter int DEAD_CYC = 4,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              cmd_on,
    output logic              cmd_ready,
    output logic [CODE_W-1:0] ctl_a,
    output logic [CODE_W-1:0] ctl_b,
    output logic              busy,
    output logic              a_on,
    output logic              done
);

    typedef enum logic [2:0] {
        S_B, B_FALL, DEAD_BA, A_RISE,
        S_A, A_FALL, DEAD_AB, B_RISE
    } state_t;

    localparam logic [CODE_W-1:0] ON_C   = CODE_W'(CODE_ON);
    localparam logic [CODE_W-1:0] OFF_C  = CODE_W'(CODE_OFF);
    localparam logic [CODE_W-1:0] STEP_C = CODE_W'(STEP);
    localparam logic [CNT_W-1:0]  DEAD_LAST =
        CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

    state_t            state, state_n;
    logic [CODE_W-1:0] a_n, b_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              done_n;

    // Codes stay within [OFF, ON], so these differences never wrap.
    function automatic logic [CODE_W-1:0] ramp_dn(input logic [CODE_W-1:0] c);
        if (c - OFF_C <= STEP_C) return OFF_C;
        return c - STEP_C;
    endfunction

    function automatic logic [CODE_W-1:0] ramp_up(input logic [CODE_W-1:0] c);
        if (ON_C - c <= STEP_C) return ON_C;
        return c + STEP_C;
    endfunction

    always_comb begin
        state_n = state;
        a_n     = ctl_a;
        b_n     = ctl_b;
        cnt_n   = cnt;
        done_n  = 1'b0;
        unique case (state)
            S_B: if (cmd_valid) begin
                if (cmd_on) state_n = B_FALL;
                else        done_n  = 1'b1;
            end
            S_A: if (cmd_valid) begin
                if (!cmd_on) state_n = A_FALL;
                else         done_n  = 1'b1;
            end
            B_FALL: begin
                b_n = ramp_dn(ctl_b);
                if (b_n == OFF_C)
                    state_n = (DEAD_CYC == 0) ? A_RISE : DEAD_BA;
            end
            A_FALL: begin
                a_n = ramp_dn(ctl_a);
                if (a_n == OFF_C)
                    state_n = (DEAD_CYC == 0) ? B_RISE : DEAD_AB;
            end
            DEAD_BA, DEAD_AB: begin
                if (cnt == DEAD_LAST) begin
                    cnt_n   = '0;
                    state_n = (state == DEAD_BA) ? A_RISE : B_RISE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            A_RISE: begin
                a_n = ramp_up(ctl_a);
                if (a_n == ON_C) begin
                    state_n = S_A;
                    done_n  = 1'b1;
                end
            end
            B_RISE: begin
                b_n = ramp_up(ctl_b);
                if (b_n == ON_C) begin
                    state_n = S_B;
                    done_n  = 1'b1;
                end
            end
            default: state_n = S_B;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_B;
            ctl_a <= OFF_C;
            ctl_b <= ON_C;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            ctl_a <= a_n;
            ctl_b <= b_n;
            cnt   <= cnt_n;
            done  <= done_n;
        end
    end

    assign cmd_ready = (state == S_A) || (state == S_B);
    assign busy      = ~cmd_ready;
    assign a_on      = (state == S_A);

endmodule

// File: tb/tb_vc_switch_driver.sv
// Bench for vc_switch_driver: vector table, corner sequences,
// and randomized commands against a sequence-level reference model.
module tb_vc_switch_driver;

    localparam int OFF   = 20;
    localparam int ON    = 200;
    localparam int STEP2 = 7;
    localparam int DEAD2 = 0;

    logic       clk = 1'b0;
    logic       r1, v1, o1, rdy1, busy1, aon1, done1;
    logic       r2, v2, o2, rdy2, busy2, aon2, done2;
    logic [7:0] a1, b1, a2, b2;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    always #5 clk = ~clk;

    vc_switch_driver dut1 (
        .clk(clk), .reset(r1), .cmd_valid(v1), .cmd_on(o1),
        .cmd_ready(rdy1), .ctl_a(a1), .ctl_b(b1),
        .busy(busy1), .a_on(aon1), .done(done1)
    );

    vc_switch_driver #(.STEP(STEP2), .DEAD_CYC(DEAD2)) dut2 (
        .clk(clk), .reset(r2), .cmd_valid(v2), .cmd_on(o2),
        .cmd_ready(rdy2), .ctl_a(a2), .ctl_b(b2),
        .busy(busy2), .a_on(aon2), .done(done2)
    );

    typedef struct {
        int a; int b; bit rdy; bit dn; bit aon;
    } exp_t;

    typedef struct {
        int cyc; int a; int b; bit rdy; bit dn; bit aon;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp1(input string t, input exp_t e);
        chk({t, "_a"}, 32'(a1), e.a);
        chk({t, "_b"}, 32'(b1), e.b);
        chk({t, "_rdy"}, 32'(rdy1), 32'(e.rdy));
        chk({t, "_done"}, 32'(done1), 32'(e.dn));
        chk({t, "_aon"}, 32'(aon1), 32'(e.aon));
    endtask

    task automatic cmp2(input string t, input exp_t e);
        chk({t, "_a"}, 32'(a2), e.a);
        chk({t, "_b"}, 32'(b2), e.b);
        chk({t, "_rdy"}, 32'(rdy2), 32'(e.rdy));
        chk({t, "_done"}, 32'(done2), 32'(e.dn));
        chk({t, "_aon"}, 32'(aon2), 32'(e.aon));
    endtask

    // Invariants on both instances every cycle.
    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if ((a1 > OFF && b1 > OFF) || a1 < OFF || a1 > ON ||
                b1 < OFF || b1 > ON || busy1 !== ~rdy1) begin
                errors++;
                $display("FAIL inv1: a=%0d b=%0d busy=%b rdy=%b", a1, b1, busy1, rdy1);
            end
            checks++;
            if ((a2 > OFF && b2 > OFF) || a2 < OFF || a2 > ON ||
                b2 < OFF || b2 > ON || busy2 !== ~rdy2) begin
                errors++;
                $display("FAIL inv2: a=%0d b=%0d busy=%b rdy=%b", a2, b2, busy2, rdy2);
            end
        end
    end

    exp_t q[$];

    // Full transition as a list of per-cycle outputs for STEP2/DEAD2.
    task automatic push_transition(input bit to_a);
        int v;
        int fall [$];
        int rise [$];
        v = ON;
        while (v > OFF) begin
            fall.push_back(v);
            v = (v - STEP2 < OFF) ? OFF : v - STEP2;
        end
        v = OFF;
        while (v < ON) begin
            rise.push_back(v);
            v = (v + STEP2 > ON) ? ON : v + STEP2;
        end
        foreach (fall[i])
            q.push_back(to_a ? exp_t'{OFF, fall[i], 0, 0, 0}
                             : exp_t'{fall[i], OFF, 0, 0, 0});
        repeat (DEAD2) q.push_back(exp_t'{OFF, OFF, 0, 0, 0});
        foreach (rise[i])
            q.push_back(to_a ? exp_t'{rise[i], OFF, 0, 0, 0}
                             : exp_t'{OFF, rise[i], 0, 0, 0});
        q.push_back(to_a ? exp_t'{ON, OFF, 1, 1, 1}
                         : exp_t'{OFF, ON, 1, 1, 0});
    endtask

    function automatic exp_t stable(input bit is_a, input bit dn);
        return is_a ? exp_t'{ON, OFF, 1, dn, 1} : exp_t'{OFF, ON, 1, dn, 0};
    endfunction

    vec_t t2 [10];
    exp_t cur;
    bit   model_a;

    initial begin
        t2[0] = '{1,  20, 200, 0, 0, 0};
        t2[1] = '{2,  20, 190, 0, 0, 0};
        t2[2] = '{18, 20, 30,  0, 0, 0};
        t2[3] = '{19, 20, 20,  0, 0, 0};
        t2[4] = '{22, 20, 20,  0, 0, 0};
        t2[5] = '{23, 20, 20,  0, 0, 0};
        t2[6] = '{24, 30, 20,  0, 0, 0};
        t2[7] = '{40, 190, 20, 0, 0, 0};
        t2[8] = '{41, 200, 20, 1, 1, 1};
        t2[9] = '{42, 200, 20, 1, 0, 1};

        r1 = 1; v1 = 0; o1 = 0;
        r2 = 1; v2 = 0; o2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        r1 = 0; r2 = 0;
        inv_en = 1;
        cmp1("t1_reset", stable(0, 0));

        // Default transition B -> A, command in cycle 0.
        v1 = 1; o1 = 1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (c == 1) v1 = 0;
            foreach (t2[i])
                if (t2[i].cyc == c)
                    cmp1($sformatf("t2_c%0d", c),
                         exp_t'{t2[i].a, t2[i].b, t2[i].rdy, t2[i].dn, t2[i].aon});
        end

        // Redundant command in S_A.
        v1 = 1; o1 = 1;
        @(negedge clk);
        v1 = 0;
        cmp1("t4_redundant", stable(1, 1));
        @(negedge clk);
        cmp1("t4_after", stable(1, 0));

        // Return to S_B, then reset during the 10th cycle of A_RISE.
        v1 = 1; o1 = 0;
        @(negedge clk);
        v1 = 0;
        for (int k = 0; k < 100 && !done1; k++) @(negedge clk);
        chk("t5_back_to_b", 32'(done1 & ~aon1), 1);
        v1 = 1; o1 = 1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c == 1) v1 = 0;
        end
        chk("t5_mid_rise_a", 32'(a1), 110);
        r1 = 1;
        @(negedge clk);
        r1 = 0;
        cmp1("t5_reset", stable(0, 0));
        @(negedge clk);
        cmp1("t5_after", stable(0, 0));

        // STEP=7, no dead time: 26-cycle ramps, done at cycle 53.
        v2 = 1; o2 = 1;
        for (int c = 1; c <= 53; c++) begin
            @(negedge clk);
            if (c == 1) v2 = 0;
            if (c == 26) cmp2("t3_c26", exp_t'{20, 25, 0, 0, 0});
            if (c == 27) cmp2("t3_c27", exp_t'{20, 20, 0, 0, 0});
            if (c == 52) cmp2("t3_c52", exp_t'{195, 20, 0, 0, 0});
            if (c == 53) cmp2("t3_c53", exp_t'{200, 20, 1, 1, 1});
        end

        // Randomized commands on the STEP=7 / no-dead-time instance.
        r2 = 1;
        @(negedge clk);
        r2 = 0;
        q.delete();
        model_a = 0;
        cur = stable(0, 0);
        for (int n = 0; n < 2000; n++) begin
            cmp2($sformatf("rnd%0d", n), cur);
            v2 = ($urandom_range(0, 3) == 0);
            o2 = $urandom_range(0, 1);
            r2 = ($urandom_range(0, 399) == 0);
            if (r2) begin
                q.delete();
                model_a = 0;
            end else if (cur.rdy && v2) begin
                if (o2 != model_a) begin
                    push_transition(o2);
                    model_a = o2;
                end else begin
                    q.push_back(stable(model_a, 1));
                end
            end
            cur = (q.size() > 0) ? q.pop_front() : stable(model_a, 0);
            @(negedge clk);
            r2 = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
